// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multicycle RV32I-subset control FSM with memory-ready stalls and sticky illegal halt
module main_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t cur, nxt;
  logic   illegal_q;
  logic   ir_w, pc_w, reg_w, mem_w, done_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt == S_HALT) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:    if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECR;
          OP_I:         nxt = S_EXECI;
          OP_JAL:       nxt = S_JAL;
          OP_BEQ:       nxt = S_BEQ;
          default:      nxt = S_HALT;
        endcase
      end
      S_MEMADR:   nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWRITE: if (mem_ready) nxt = S_FETCH;
      S_MEMWB, S_ALUWB, S_BEQ:   nxt = S_FETCH;
      S_EXECR, S_EXECI, S_JAL:   nxt = S_ALUWB;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_FETCH;
    endcase
  end

  always_comb begin
    alu_op     = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    done_w     = 1'b0;
    case (cur)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_w       = mem_ready;
        pc_w       = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        done_w     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        done_w  = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_w      = 1'b1;
      end
      S_ALUWB: begin
        reg_w  = 1'b1;
        done_w = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_w      = zero;
        done_w    = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset holds state at FETCH, where ir/pc enables follow mem_ready; mask them while reset is low.
  assign ir_write   = rst_n & ir_w;
  assign pc_write   = rst_n & pc_w;
  assign reg_write  = rst_n & reg_w;
  assign mem_write  = rst_n & mem_w;
  assign instr_done = rst_n & done_w;
  assign illegal    = illegal_q;
  assign state      = cur;

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - vector table, directed corner sequences and randomized instruction-level model for main_fsm
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;
  logic       adr_src, ir_write, pc_write, reg_write, mem_write, instr_done, illegal;
  logic [3:0] state;

  main_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .mem_write(mem_write),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'h03, SW = 7'h23, RT = 7'h33, IT = 7'h13, JL = 7'h6f, BQ = 7'h63;

  typedef struct {
    logic [6:0]  op;
    logic        zero;
    logic        mr;
    logic [18:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [18:0] obs, snap;

  assign obs = {state, alu_op, alu_src_a, alu_src_b, result_src, adr_src,
                ir_write, pc_write, reg_write, mem_write, instr_done, illegal};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the edge, sample at the falling edge, advance past the next rising edge.
  task automatic cyc(input logic [6:0] o, input logic z, input logic m);
    op = o; zero = z; mem_ready = m;
    @(negedge clk);
    snap = obs;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [6:0] o, input logic z, input logic m, input logic [3:0] st,
                              input logic [1:0] aop, input logic [1:0] sa, input logic [1:0] sb,
                              input logic [1:0] rs, input logic adr, input logic [4:0] en, input logic il);
    vec_t v;
    v.op = o; v.zero = z; v.mr = m;
    v.exp = {st, aop, sa, sb, rs, adr, en, il};
    return v;
  endfunction

  function automatic vec_t f_fetch(input logic [6:0] o, input logic z);
    return mk(o, z, 1'b1, 4'd0, 2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 5'b11000, 1'b0);
  endfunction

  function automatic vec_t f_decode(input logic [6:0] o, input logic z);
    return mk(o, z, 1'b1, 4'd1, 2'd0, 2'd1, 2'd1, 2'd0, 1'b0, 5'b00000, 1'b0);
  endfunction

  function automatic vec_t f_aluwb(input logic [6:0] o);
    return mk(o, 1'b0, 1'b1, 4'd7, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 5'b00101, 1'b0);
  endfunction

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; op = LW; zero = 1'b0; mem_ready = 1'b1;

    // lw, R, beq taken, beq not taken, jal, I-type: one record per cycle
    tbl.push_back(f_fetch(LW, 0));
    tbl.push_back(f_decode(LW, 0));
    tbl.push_back(mk(LW, 0, 1, 4'd2, 2'd0, 2'd2, 2'd1, 2'd0, 1'b0, 5'b00000, 1'b0));
    tbl.push_back(mk(LW, 0, 1, 4'd3, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 5'b00000, 1'b0));
    tbl.push_back(mk(LW, 0, 1, 4'd4, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0, 5'b00101, 1'b0));
    tbl.push_back(f_fetch(RT, 0));
    tbl.push_back(f_decode(RT, 0));
    tbl.push_back(mk(RT, 0, 1, 4'd6, 2'd2, 2'd2, 2'd0, 2'd0, 1'b0, 5'b00000, 1'b0));
    tbl.push_back(f_aluwb(RT));
    tbl.push_back(f_fetch(BQ, 1));
    tbl.push_back(f_decode(BQ, 1));
    tbl.push_back(mk(BQ, 1, 1, 4'd10, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 5'b01001, 1'b0));
    tbl.push_back(f_fetch(BQ, 0));
    tbl.push_back(f_decode(BQ, 0));
    tbl.push_back(mk(BQ, 0, 1, 4'd10, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 5'b00001, 1'b0));
    tbl.push_back(f_fetch(JL, 0));
    tbl.push_back(f_decode(JL, 0));
    tbl.push_back(mk(JL, 0, 1, 4'd9, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 5'b01000, 1'b0));
    tbl.push_back(f_aluwb(JL));
    tbl.push_back(f_fetch(IT, 0));
    tbl.push_back(f_decode(IT, 0));
    tbl.push_back(mk(IT, 0, 1, 4'd8, 2'd2, 2'd2, 2'd1, 2'd0, 1'b0, 5'b00000, 1'b0));
    tbl.push_back(f_aluwb(IT));

    #2;
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_enables", {26'd0, ir_write, pc_write, reg_write, mem_write, instr_done, illegal}, 32'd0);
    chk("reset_selects", {24'd0, alu_src_b, result_src, alu_src_a, alu_op}, {24'd0, 2'd2, 2'd2, 2'd0, 2'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].op, tbl[i].zero, tbl[i].mr);
      chk($sformatf("vec%0d", i), {13'd0, snap}, {13'd0, tbl[i].exp});
    end

    // fetch stall: three mem_ready-low cycles, then a single ir/pc pulse
    for (int i = 0; i < 3; i++) begin
      cyc(RT, 0, 0);
      chk($sformatf("fstall%0d_state", i), {28'd0, snap[18:15]}, 32'd0);
      chk($sformatf("fstall%0d_irpc", i), {30'd0, snap[5:4]}, 32'd0);
    end
    cyc(RT, 0, 1);
    chk("fstall_release_irpc", {30'd0, snap[5:4]}, 32'd3);
    cyc(RT, 0, 1);
    chk("fstall_decode", {26'd0, snap[18:15], snap[5:4]}, {26'd0, 4'd1, 2'd0});
    cyc(RT, 0, 1);
    cyc(RT, 0, 1);

    // sw with two wait cycles in MEMWRITE
    cyc(SW, 0, 1);
    cyc(SW, 0, 1);
    cyc(SW, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(SW, 0, (i == 2));
      chk($sformatf("sw_wait%0d", i), {25'd0, snap[18:15], snap[2], snap[1]},
          {25'd0, 4'd5, 1'b1, (i == 2)});
    end
    chk("sw_back_to_fetch", {28'd0, state}, 32'd0);

    // reset in MEMWRITE abandons the store at once
    cyc(SW, 0, 1);
    cyc(SW, 0, 1);
    cyc(SW, 0, 1);
    chk("midrst_in_memwrite", {28'd0, state}, 32'd5);
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", {28'd0, state}, 32'd0);
    chk("midrst_enables", {27'd0, ir_write, pc_write, reg_write, mem_write, instr_done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // randomized instructions against an instruction-level model
    for (int k = 0; k < 60; k++) begin
      int          kind, sf, sm, n, base, done_cnt, done_at;
      int          c_ir, c_pc, c_rw, c_mw;
      logic        z, mem_k, m;
      logic [6:0]  opc, o;
      logic [6:0]  ops[6];
      ops = '{LW, SW, RT, IT, JL, BQ};
      kind  = $urandom_range(0, 5);
      opc   = ops[kind];
      mem_k = (kind <= 1);
      sf    = $urandom_range(0, 3);
      sm    = mem_k ? $urandom_range(0, 3) : 0;
      z     = 1'($urandom_range(0, 1));
      case (kind)
        0:       base = 5;
        5:       base = 3;
        default: base = 4;
      endcase
      n = base + sf + sm;
      done_cnt = 0; done_at = -1; c_ir = 0; c_pc = 0; c_rw = 0; c_mw = 0;
      for (int t = 0; t < n; t++) begin
        if (t < sf) m = 1'b0;
        else if (t == sf) m = 1'b1;
        else if (mem_k && t >= sf + 3 && t < sf + 3 + sm) m = 1'b0;
        else if (mem_k && t == sf + 3 + sm) m = 1'b1;
        else m = 1'($urandom_range(0, 1));
        o = (t == sf + 1 || t == sf + 2) ? opc : 7'($urandom);
        cyc(o, z, m);
        c_ir += int'(snap[5]);
        c_pc += int'(snap[4]);
        c_rw += int'(snap[3]);
        c_mw += int'(snap[2]);
        if (snap[1]) begin
          done_cnt++;
          done_at = t;
        end
      end
      chk($sformatf("rnd%0d_op%0h_done_cnt", k, opc), done_cnt, 1);
      chk($sformatf("rnd%0d_op%0h_done_at", k, opc), done_at, n - 1);
      chk($sformatf("rnd%0d_op%0h_ir", k, opc), c_ir, 1);
      chk($sformatf("rnd%0d_op%0h_pc", k, opc), c_pc, 1 + int'(kind == 4) + int'(kind == 5 && z));
      chk($sformatf("rnd%0d_op%0h_rw", k, opc), c_rw, int'(kind == 0 || kind == 2 || kind == 3 || kind == 4));
      chk($sformatf("rnd%0d_op%0h_mw", k, opc), c_mw, (kind == 1) ? sm + 1 : 0);
      chk($sformatf("rnd%0d_op%0h_next_fetch", k, opc), {27'd0, illegal, state}, 32'd0);
    end

    // illegal opcode: sticky halt for ten cycles, cleared only by reset
    cyc(7'h7f, 0, 1);
    cyc(7'h7f, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(7'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk($sformatf("halt%0d", i), {13'd0, snap[18:15], snap[5:0]}, {13'd0, 4'd11, 6'b000001});
    end
    rst_n = 1'b0;
    #1;
    chk("halt_reset", {27'd0, illegal, state}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(RT, 0, 1);
    chk("after_halt_fetch", {28'd0, snap[18:15]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle control state machine for the RV32I subset core (lw, sw, R-type, I-type ALU, jal, beq). It sits directly upstream of the ALU decoder: it produces the 2-bit `alu_op` that the decoder combines with funct3/funct7b5 into ALUControl, and it drives every datapath select and write enable. It also adds a memory-ready handshake and a sticky illegal-opcode halt.

## Interface
- No parameters.
- `clk` input 1: single clock, all state changes on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `op` input 7: instruction opcode, bits [6:0] of the instruction register.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory has completed the current access this cycle.
- `alu_op` output 2: to ALU decoder; 00 add, 01 subtract, 10 funct-decoded.
- `alu_src_a` output 2: 00 PC, 01 OldPC, 10 register A.
- `alu_src_b` output 2: 00 register B, 01 immediate, 10 constant 4.
- `result_src` output 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `adr_src` output 1: 0 PC, 1 Result.
- `ir_write`, `pc_write`, `reg_write`, `mem_write` output 1 each: write enables.
- `instr_done` output 1: one-cycle pulse on the final cycle of each instruction.
- `illegal` output 1: sticky; unsupported opcode decoded.
- `state` output 4: current state encoding, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, HALT 11.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, jal 1101111, beq 1100011.
- Transitions: FETCH -> DECODE when mem_ready, else stay. DECODE -> MEMADR (lw/sw), EXECR (R), EXECI (I), JAL (jal), BEQ (beq), HALT (any other op). MEMADR -> MEMREAD (lw) or MEMWRITE (sw). MEMREAD -> MEMWB when mem_ready, else stay. MEMWRITE -> FETCH when mem_ready, else stay. MEMWB, ALUWB, BEQ -> FETCH. EXECR, EXECI, JAL -> ALUWB. HALT -> HALT until reset.
- `op` sampled in DECODE and MEMADR only; changes elsewhere ignored.
- Outputs are a Moore decode of `state`, except where qualified; any select not listed is 00/0, any enable not listed is 0:
  - FETCH: alu_src_b 10, result_src 10, ir_write = mem_ready, pc_write = mem_ready.
  - DECODE: alu_src_a 01, alu_src_b 01, alu_op 00.
  - MEMADR: alu_src_a 10, alu_src_b 01, alu_op 00.
  - MEMREAD: adr_src 1, result_src 00.
  - MEMWB: result_src 01, reg_write 1.
  - MEMWRITE: adr_src 1, mem_write 1 (held every cycle until mem_ready).
  - EXECR: alu_src_a 10, alu_src_b 00, alu_op 10.
  - EXECI: alu_src_a 10, alu_src_b 01, alu_op 10.
  - JAL: alu_src_a 01, alu_src_b 10, alu_op 00, result_src 00, pc_write 1.
  - ALUWB: result_src 00, reg_write 1.
  - BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00, pc_write = zero.
  - HALT: all enables 0, illegal 1.
- `instr_done` = 1 in MEMWB, ALUWB, BEQ, and in MEMWRITE when mem_ready.
- `illegal` set on entry to HALT, cleared only by reset.

## Timing
- Reset (rst_n low, any time, asynchronous): state = FETCH; illegal = 0; all write enables and instr_done forced 0 while rst_n low regardless of mem_ready; selects show FETCH values.
- First edge after rst_n rises evaluates FETCH normally.
- Cycles per instruction with mem_ready always 1: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- Each mem_ready-low cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle; no enable pulses repeat during a stall except mem_write.
- Reset mid-instruction: abandoned immediately, no further enables; next instruction starts at FETCH.
- beq with zero = 0: pc_write 0, still returns to FETCH after one BEQ cycle.

## Test plan
- Reset: hold rst_n low with mem_ready=1 -> state 0, ir_write/pc_write/reg_write/mem_write/instr_done/illegal all 0.
- lw, mem_ready=1: op 0000011 -> states 0,1,2,3,4,0; reg_write and instr_done only in state 4; result_src 01 there.
- sw with mem_ready low 2 cycles in MEMWRITE: op 0100011 -> state 5 for 3 cycles, mem_write 1 all 3, instr_done once on third, then state 0.
- R-type then beq: op 0110011 -> alu_op 10 in state 6, reg_write in 7; op 1100011 with zero=1 -> alu_op 01, pc_write 1 in state 10; repeat with zero=0 -> pc_write 0.
- Fetch stall: mem_ready=0 for 3 cycles in FETCH -> state 0 held, ir_write/pc_write 0, then 1 for single cycle when mem_ready=1.
- Illegal op 1111111 -> state 11, illegal 1, held 10 cycles with no enables; rst_n pulse low -> state 0, illegal 0.
